div_seq_unit: RTL and testbench

Sequential signed divider that answers the control FSM's divide handshake (dloadab, then div). It latches A and B and runs a 32-iteration restoring division on operand magnitudes, one quotient bit per cycle. It then applies MIPS sign rules and presents remainder on hi and quotient on lo for the HI/LO register write. It flags divide-by-zero so the control FSM can take its DIVZERO exception path.

---
 rtl/div_seq_unit_pkg.sv | 14 +
 rtl/div_seq_unit.sv | 113 +++++++++++
 tb/tb_div_seq_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/div_seq_unit_pkg.sv
// rtl/div_seq_unit_pkg.sv - shared datapath width and divider state encoding
package div_seq_unit_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADED = 3'd1,
    S_CALC   = 3'd2,
    S_SIGN   = 3'd3,
    S_DONE   = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - sequential signed restoring divider, remainder on hi, quotient on lo
module div_seq_unit
  import div_seq_unit_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dloadab,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] areg, breg, bmag, rem, quo;
  logic [WIDTH-1:0] rem_sh, quo_sh;
  logic [CW-1:0]    cnt;
  logic             sa, sq;

  // rem stays below |B| <= 2^(WIDTH-1), so the shifted partial remainder fits WIDTH bits
  always_comb begin
    rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_sh = {quo[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      areg    <= '0;
      breg    <= '0;
      bmag    <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      sa      <= 1'b0;
      sq      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dloadab) begin
            areg  <= a;
            breg  <= b;
            state <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (dloadab) begin
            areg <= a;
            breg <= b;
          end else if (div) begin
            if (breg == '0) begin
              divzero <= 1'b1;
              state   <= S_DONE;
            end else begin
              divzero <= 1'b0;
              sa      <= areg[WIDTH-1];
              sq      <= areg[WIDTH-1] ^ breg[WIDTH-1];
              quo     <= areg[WIDTH-1] ? -areg : areg;
              bmag    <= breg[WIDTH-1] ? -breg : breg;
              rem     <= '0;
              cnt     <= CW'(WIDTH - 1);
              busy    <= 1'b1;
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (rem_sh >= bmag) begin
            rem <= rem_sh - bmag;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= quo_sh;
          end
          if (cnt == '0) state <= S_SIGN;
          else           cnt   <= cnt - 1'b1;
        end
        S_SIGN: begin
          lo    <= sq ? -quo : quo;
          hi    <= sa ? -rem : rem;
          busy  <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b1;
          if (dloadab) begin
            areg  <= a;
            breg  <= b;
            state <= S_LOADED;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// tb/tb_div_seq_unit.sv - scoreboard bench for div_seq_unit against signed-arithmetic reference
module tb_div_seq_unit;

  logic        clk = 1'b0;
  logic        reset, dloadab, div;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, divzero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_hi, m_lo;
  int          vectors = 0;
  int          miscompares = 0;

  div_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .dloadab(dloadab), .div(div),
    .a(a), .b(b), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: truncating signed division; a zero divisor leaves hi/lo as they were
  task automatic push_expected(input logic [31:0] av, input logic [31:0] bv);
    exp_t   e;
    longint sa, sb, q, r;
    if (bv == 32'd0) begin
      e.dz = 1'b1;
    end else begin
      sa   = longint'($signed(av));
      sb   = longint'($signed(bv));
      q    = sa / sb;
      r    = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      e.dz = 1'b0;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sbq.push_back(e);
  endtask

  // mode 0: plain run, 1: dloadab/div pokes during CALC, 2: reset during CALC
  task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input int mode);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    @(posedge clk); #1;
    dloadab = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    dloadab = 1'b0; div = 1'b1;
    a = $urandom; b = $urandom;
    if (mode != 2) push_expected(av, bv);
    @(posedge clk); #1;
    div = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (mode == 1 && i == 5) begin dloadab = 1'b1; div = 1'b1; a = 32'd1; b = 32'd1; end
      if (mode == 1 && i == 8) begin dloadab = 1'b0; div = 1'b0; end
      if (mode == 2 && i == 10) reset = 1'b0;
      @(posedge clk); #1;
      if (mode == 2 && i == 10) begin
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_divzero", {31'd0, divzero}, 32'd0);
      end
      if (done && !got) begin
        got = 1'b1;
        n   = i;
      end
      if (got && mode != 2) break;
    end
    if (mode == 2) chk("no_done_after_reset", {31'd0, got}, 32'd0);
    else           chk("done_latency", n, (bv == 32'd0) ? 32'd1 : 32'd34);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("divzero", {31'd0, divzero}, {31'd0, e.dz});
      end
    end
  end

  initial begin
    logic [31:0] av, bv;
    reset = 1'b0; dloadab = 1'b0; div = 1'b0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_divzero", {31'd0, divzero}, 32'd0);
    reset = 1'b1;

    // div without a prior load is ignored in IDLE
    @(posedge clk); #1;
    div = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    div = 1'b0;
    chk("idle_div_busy", {31'd0, busy}, 32'd0);

    do_div(32'd100, 32'd7, 0);
    do_div(32'hFFFFFF9C, 32'd7, 0);
    do_div(32'd100, 32'hFFFFFFF9, 0);
    do_div(32'd5, 32'd0, 0);
    do_div(32'd9, 32'd3, 0);
    do_div(32'h80000000, 32'hFFFFFFFF, 0);
    do_div(32'h80000000, 32'd1, 0);
    do_div(32'd7, 32'h80000000, 0);
    do_div(32'h80000000, 32'h80000000, 0);
    do_div(32'd100, 32'd7, 1);
    do_div(32'd100, 32'd7, 2);
    do_div(32'd9, 32'd0, 0);

    for (int k = 0; k < 40; k++) begin
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 9))
        0: bv = 32'd0;
        1: bv = $urandom_range(1, 15);
        2: bv = 32'hFFFFFFFF;
        3: av = 32'h80000000;
        4: begin av = $urandom_range(0, 100); bv = 32'hFFFFFFFF - $urandom_range(0, 20); end
        default: ;
      endcase
      do_div(av, bv, 0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
